// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared return-address-stack defaults and prediction entry type
//
// Shared by the RAS (fetch side) and the return-check path (execute side).
//   RAS_ADDR_W  : return address width
//   RAS_TOS_W   : stack-top pointer snapshot width
//   RAS_CNT_W   : statistics counter width
//   RAS_QDEPTH  : pending-prediction queue depth
//   ras_entry_t : {addr, tos} as carried from fetch to execute
package ras_pkg;

    localparam int RAS_ADDR_W = 32;
    localparam int RAS_TOS_W  = 2;
    localparam int RAS_CNT_W  = 16;
    localparam int RAS_QDEPTH = 4;

    typedef struct packed {
        logic [RAS_ADDR_W-1:0] addr;
        logic [RAS_TOS_W-1:0]  tos;
    } ras_entry_t;

endpackage

// File: rtl/ret_fifo.sv
// rtl/ret_fifo.sv - in-order FIFO of pending return predictions with single-cycle clear
//
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : empties the FIFO at the next edge; overrides push and pop
//   push        : write push_data (ignored while full)
//   push_data   : entry to append
//   pop         : drop the head entry (ignored while empty)
//   head        : oldest entry, valid while empty is low
//   full, empty : occupancy flags
module ret_fifo #(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;
    logic              do_push;
    logic              do_pop;

    assign full    = (occ == (AW+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign head    = mem[rd_ptr];

    // A clear discards anything offered in the same cycle.
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    // Storage needs no reset: occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/ret_check.sv
// rtl/ret_check.sv - return-prediction verifier: checks resolved returns against queued predictions
//
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   pred_valid/pred_ready           : fetch-side prediction handshake
//   pred_addr, pred_tos             : predicted return address and stack-top before the pop
//   res_valid/res_ready             : execute-side resolve handshake
//   res_target                      : actual return target
//   flush_in                        : pipeline flush, empties the queue, blocks both handshakes
//   chk_valid, chk_hit              : one-cycle check result, the cycle after the resolve
//   mis_valid                       : one-cycle mispredict pulse
//   mis_target, mis_tos             : redirect address / stack-top to restore, held until next miss
//   hit_cnt, miss_cnt               : saturating statistics, untouched by flush_in
module ret_check
    import ras_pkg::*;
#(
    parameter int W     = RAS_ADDR_W,
    parameter int DEPTH = RAS_QDEPTH,
    parameter int TOS_W = RAS_TOS_W,
    parameter int CNT_W = RAS_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    output logic             pred_ready,
    input  logic [W-1:0]     pred_addr,
    input  logic [TOS_W-1:0] pred_tos,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [W-1:0]     res_target,
    input  logic             flush_in,
    output logic             chk_valid,
    output logic             chk_hit,
    output logic             mis_valid,
    output logic [W-1:0]     mis_target,
    output logic [TOS_W-1:0] mis_tos,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    // Same layout as ras_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [W-1:0]     addr;
        logic [TOS_W-1:0] tos;
    } entry_t;

    entry_t push_entry;
    entry_t head_entry;
    logic   q_full;
    logic   q_empty;
    logic   accept;
    logic   check;
    logic   hit;
    logic   miss;
    logic   q_clear;

    assign pred_ready = !q_full && !flush_in;
    assign res_ready  = !q_empty && !flush_in;

    assign accept     = pred_valid && pred_ready;
    assign check      = res_valid && res_ready;

    assign hit        = (res_target == head_entry.addr);
    assign miss       = check && !hit;

    // A miss means everything younger than the head was fetched down the
    // wrong path, including a prediction arriving this very cycle, so the
    // clear overrides the push inside the FIFO.
    assign q_clear    = flush_in || miss;

    assign push_entry.addr = pred_addr;
    assign push_entry.tos  = pred_tos;

    ret_fifo #(
        .DATA_W ($bits(entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (q_clear),
        .push      (accept),
        .push_data (push_entry),
        .pop       (check && hit),
        .head      (head_entry),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Check results and redirect information, one cycle after the resolve.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_valid  <= 1'b0;
            chk_hit    <= 1'b0;
            mis_valid  <= 1'b0;
            mis_target <= '0;
            mis_tos    <= '0;
        end else begin
            chk_valid <= check;
            chk_hit   <= check && hit;
            mis_valid <= miss;
            if (miss) begin
                mis_target <= res_target;
                mis_tos    <= head_entry.tos;
            end
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (check && hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ret_check.sv
// tb/tb_ret_check.sv - self-checking bench for ret_check
module tb_ret_check;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic        pred_ready;
    logic [31:0] pred_addr;
    logic [1:0]  pred_tos;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_target;
    logic        flush_in;
    logic        chk_valid;
    logic        chk_hit;
    logic        mis_valid;
    logic [31:0] mis_target;
    logic [1:0]  mis_tos;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ret_check #(.W(32), .DEPTH(DEPTH), .TOS_W(2), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_ready (pred_ready),
        .pred_addr  (pred_addr),
        .pred_tos   (pred_tos),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_target (res_target),
        .flush_in   (flush_in),
        .chk_valid  (chk_valid),
        .chk_hit    (chk_hit),
        .mis_valid  (mis_valid),
        .mis_target (mis_target),
        .mis_tos    (mis_tos),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending predictions plus plain integer tallies.
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  tos;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_hits       = 0;
    int          m_miss       = 0;
    logic        e_chk_valid  = 1'b0;
    logic        e_chk_hit    = 1'b0;
    logic        e_mis_valid  = 1'b0;
    logic [31:0] e_mis_target = '0;
    logic [1:0]  e_mis_tos    = '0;
    logic        m_acc;
    logic        m_chk;
    m_ent_t      m_new;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_hits       = 0;
            m_miss       = 0;
            e_chk_valid  = 1'b0;
            e_chk_hit    = 1'b0;
            e_mis_valid  = 1'b0;
            e_mis_target = '0;
            e_mis_tos    = '0;
        end else begin
            m_acc = pred_valid && (mq.size() < DEPTH) && !flush_in;
            m_chk = res_valid && (mq.size() > 0) && !flush_in;
            m_new.addr = pred_addr;
            m_new.tos  = pred_tos;
            e_chk_valid = m_chk;
            e_chk_hit   = 1'b0;
            e_mis_valid = 1'b0;
            if (flush_in) begin
                mq.delete();
            end else if (m_chk && (res_target == mq[0].addr)) begin
                e_chk_hit = 1'b1;
                m_hits++;
                void'(mq.pop_front());
                if (m_acc) mq.push_back(m_new);
            end else if (m_chk) begin
                e_mis_valid  = 1'b1;
                m_miss++;
                e_mis_target = res_target;
                e_mis_tos    = mq[0].tos;
                mq.delete();
            end else if (m_acc) begin
                mq.push_back(m_new);
            end
        end
    end

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("pred_ready", {31'd0, pred_ready}, {31'd0, (mq.size() < DEPTH) && !flush_in});
        check("res_ready",  {31'd0, res_ready},  {31'd0, (mq.size() > 0) && !flush_in});
        check("chk_valid",  {31'd0, chk_valid},  {31'd0, e_chk_valid});
        check("chk_hit",    {31'd0, chk_hit},    {31'd0, e_chk_hit});
        check("mis_valid",  {31'd0, mis_valid},  {31'd0, e_mis_valid});
        check("mis_target", mis_target,          e_mis_target);
        check("mis_tos",    {30'd0, mis_tos},    {30'd0, e_mis_tos});
        check("hit_cnt",    {16'd0, hit_cnt},    {16'd0, sat16(m_hits)});
        check("miss_cnt",   {16'd0, miss_cnt},   {16'd0, sat16(m_miss)});
    end

    task automatic set_in(input logic pv, input logic [31:0] pa, input logic [1:0] pt,
                          input logic rv, input logic [31:0] rt, input logic fl);
        pred_valid = pv;
        pred_addr  = pa;
        pred_tos   = pt;
        res_valid  = rv;
        res_target = rt;
        flush_in   = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        check("rst pred_ready", {31'd0, pred_ready}, 32'd1);
        check("rst res_ready",  {31'd0, res_ready},  32'd0);
        check("rst hit_cnt",    {16'd0, hit_cnt},    32'd0);
        check("rst mis_target", mis_target,          32'd0);
        reset = 1'b1;
        tick();

        // Single hit
        set_in(1'b1, 32'h1000, 2'd2, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 2'd0, 1'b1, 32'h1000, 1'b0);
        tick();
        check("t1 chk_valid", {31'd0, chk_valid}, 32'd1);
        check("t1 chk_hit",   {31'd0, chk_hit},   32'd1);
        check("t1 mis_valid", {31'd0, mis_valid}, 32'd0);
        check("t1 hit_cnt",   {16'd0, hit_cnt},   32'd1);
        check("t1 res_ready", {31'd0, res_ready}, 32'd0);

        // Mispredict on the older of two entries
        set_in(1'b1, 32'h2000, 2'd1, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b1, 32'h3000, 2'd3, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 2'd0, 1'b1, 32'h2004, 1'b0);
        tick();
        check("t2 mis_valid",  {31'd0, mis_valid}, 32'd1);
        check("t2 mis_target", mis_target,         32'h2004);
        check("t2 mis_tos",    {30'd0, mis_tos},   32'd1);
        check("t2 miss_cnt",   {16'd0, miss_cnt},  32'd1);
        check("t2 res_ready",  {31'd0, res_ready}, 32'd0);
        idle();
        tick();
        check("t2 pulse end", {31'd0, mis_valid}, 32'd0);
        check("t2 target held", mis_target, 32'h2004);

        // Full queue stalls the fifth prediction until a hit frees a slot
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h4000 + 32'(4 * i), 2'(i), 1'b0, 32'h0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h4010, 2'd0, 1'b0, 32'h0, 1'b0);
        #1;
        check("t3 full pred_ready", {31'd0, pred_ready}, 32'd0);
        tick();
        set_in(1'b1, 32'h4010, 2'd0, 1'b1, 32'h4000, 1'b0);
        #1;
        check("t3 pop no comb ready", {31'd0, pred_ready}, 32'd0);
        tick();
        set_in(1'b1, 32'h4010, 2'd0, 1'b0, 32'h0, 1'b0);
        #1;
        check("t3 ready after pop", {31'd0, pred_ready}, 32'd1);
        tick();
        for (int i = 1; i < 5; i++) begin
            set_in(1'b0, 32'h0, 2'd0, 1'b1, 32'h4000 + 32'(4 * i), 1'b0);
            tick();
            check("t3 drain hit", {31'd0, chk_hit}, 32'd1);
        end
        check("t3 hit_cnt", {16'd0, hit_cnt}, 32'd6);

        // Same-cycle push is dropped by a miss
        set_in(1'b1, 32'h6000, 2'd2, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b1, 32'h5000, 2'd0, 1'b1, 32'h7777, 1'b0);
        tick();
        check("t4 mis_tos",   {30'd0, mis_tos},   32'd2);
        check("t4 res_ready", {31'd0, res_ready}, 32'd0);
        set_in(1'b0, 32'h0, 2'd0, 1'b1, 32'h5000, 1'b0);
        tick();
        check("t4 no check", {31'd0, chk_valid}, 32'd0);
        check("t4 miss_cnt", {16'd0, miss_cnt},  32'd2);

        // Flush with three entries queued and a resolve pending
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h9000 + 32'(4 * i), 2'(i), 1'b0, 32'h0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'hA000, 2'd1, 1'b1, 32'h9000, 1'b1);
        #1;
        check("t5 flush pred_ready", {31'd0, pred_ready}, 32'd0);
        check("t5 flush res_ready",  {31'd0, res_ready},  32'd0);
        tick();
        idle();
        #1;
        check("t5 chk_valid", {31'd0, chk_valid}, 32'd0);
        check("t5 res_ready", {31'd0, res_ready}, 32'd0);
        check("t5 hit_cnt",   {16'd0, hit_cnt},   32'd6);
        check("t5 miss_cnt",  {16'd0, miss_cnt},  32'd2);
        tick();

        // Saturate the hit counter with back-to-back hits
        set_in(1'b1, 32'h8000, 2'd3, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b1, 32'h8000, 2'd3, 1'b1, 32'h8000, 1'b0);
        for (int i = 0; i < 65535; i++) tick();
        set_in(1'b0, 32'h0, 2'd0, 1'b1, 32'h8000, 1'b0);
        tick();
        check("t6 last hit", {31'd0, chk_hit}, 32'd1);
        idle();
        tick();
        check("t6 hit_cnt sat", {16'd0, hit_cnt},  32'h0000FFFF);
        check("t6 miss_cnt",    {16'd0, miss_cnt}, 32'd2);

        // Asynchronous reset mid-operation
        set_in(1'b1, 32'hB000, 2'd1, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        idle();
        reset = 1'b0;
        #1;
        check("t7 rst hit_cnt",   {16'd0, hit_cnt},   32'd0);
        check("t7 rst miss_cnt",  {16'd0, miss_cnt},  32'd0);
        check("t7 rst res_ready", {31'd0, res_ready}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
